position_servo: RTL
===================

POSITION_SERVO -- requirements
Module: position_servo

Interface
REQ-001 Parameter clk_freq_hz, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter counter_width, default 32, encoder/target position width W.
REQ-003 Parameter pwm_counter_width, default 16, duty width P.
REQ-004 Parameter deadband, default 2, largest |error| treated as on-target.
REQ-005 Parameter kp_shift, default 0, proportional gain: command = |error| >> kp_shift.
REQ-006 Parameter slew_step, default 1000, maximum duty increase per cycle.
REQ-007 Parameter settle_cycles, default 4, consecutive on-target cycles before in_position.
REQ-008 Parameter stall_cycles, default 100, cycles without error improvement before fault.
REQ-009 sys_clk  in  1  single clock; all logic rising-edge.
REQ-010 reset_n  in  1  asynchronous active-low reset.
REQ-011 enable  in  1  1 = closed-loop control; 0 = passthrough.
REQ-012 encoder_position  in  W  current position, modulo 2^W.
REQ-013 target_position  in  W  demanded position, modulo 2^W.
REQ-014 pwm_duty_in  in  P  passthrough duty when disabled; duty ceiling when enabled.
REQ-015 dir_in  in  rotation_direction_t  passthrough direction when disabled.
REQ-016 fault_clear  in  1  single-cycle pulse that clears a latched fault.
REQ-017 pwm_duty_out  out  P  registered duty command.
REQ-018 dir_out  out  rotation_direction_t  registered direction (DIR_NONE/CW/CCW/BRAKE).
REQ-019 in_position  out  1  settled on target.
REQ-020 fault  out  1  stall fault latched.

Function
REQ-021 error SHALL be target_position - encoder_position, modulo 2^W; error > (2^W-1)/2 SHALL mean CCW with magnitude -error, otherwise CW with magnitude error; error == (2^W-1)/2 is CW.
REQ-022 cmd SHALL be min(magnitude >> kp_shift, pwm_duty_in), saturated to P bits before comparison.
REQ-023 All outputs SHALL be registered; each output reflects the inputs of the previous cycle (latency 1).
REQ-024 States SHALL be DISABLED, TRACK, SETTLE, HOLD, FAULT.
REQ-025 DISABLED: dir_out = dir_in, pwm_duty_out = pwm_duty_in, in_position = 0; enable = 1 -> TRACK if magnitude > deadband, else SETTLE.
REQ-026 TRACK: dir_out = error direction; pwm_duty_out = min(cmd, previous duty + slew_step), and falls to cmd immediately when cmd < previous duty; the addition is saturated at 2^P-1.
REQ-027 TRACK direction reversal (CW<->CCW) SHALL output one cycle of DIR_BRAKE with duty 0, then ramp from 0.
REQ-028 TRACK -> SETTLE when magnitude <= deadband.
REQ-029 SETTLE: dir_out = DIR_BRAKE, duty 0, settle counter increments each on-target cycle.
REQ-030 SETTLE -> HOLD when the counter reaches settle_cycles; SETTLE -> TRACK, counter cleared, when magnitude > deadband.
REQ-031 HOLD: DIR_BRAKE, duty 0, in_position = 1; HOLD -> TRACK, in_position = 0, when magnitude > deadband.
REQ-032 Stall monitor: on TRACK entry best = magnitude and stall counter = 0.
REQ-033 Stall monitor, each TRACK cycle: magnitude < best loads best and clears the counter; otherwise the counter increments.
REQ-034 Stall monitor: a target_position change SHALL also load best and clear the counter.
REQ-035 Stall counter reaching stall_cycles -> FAULT: fault = 1, DIR_BRAKE, duty 0, in_position = 0.
REQ-036 FAULT SHALL hold until fault_clear; fault_clear -> TRACK/SETTLE by REQ-025 rules if enable = 1, else DISABLED; fault_clear outside FAULT SHALL be ignored.
REQ-037 enable = 0 in any state except FAULT -> DISABLED next cycle, counters cleared.
REQ-038 Counter widths SHALL be derived from the parameters with $clog2; no counter wraps.

Reset
REQ-039 reset_n = 0 SHALL immediately, without a clock, force state DISABLED, dir_out = DIR_NONE, pwm_duty_out = 0, in_position = 0, fault = 0, counters 0.
REQ-040 Reset deassertion SHALL take effect on the first following sys_clk edge; reset mid-move SHALL abandon the move with no residual duty.

Verification (W=32, P=16, defaults, pwm_duty_in=0xFFFF unless stated)
REQ-041 encoder 0, enable 1, target 100 -> next cycle dir_out CW, duty 100.
REQ-042 From CW, target 2^32-101 -> one cycle BRAKE/duty 0, then CCW/duty 101.
REQ-043 encoder 1000, target 500 -> CCW, duty 500; encoder set = target -> BRAKE next cycle, in_position high 4 cycles later.
REQ-044 target 100000, encoder held 0 -> duty 1000, 2000, ... capped at 0xFFFF; fault high 100 cycles after TRACK entry; fault_clear -> TRACK, fault 0.
REQ-045 enable 0, dir_in CW, pwm_duty_in 500 -> next cycle dir_out CW, duty 500, in_position 0.
REQ-046 reset_n low mid-TRACK between clock edges -> outputs DIR_NONE/0/0/0 before the next edge.

Source files
------------

// File: rtl/position_servo_if.sv
// Position servo bus: the direction type shared by the servo and its users,
// plus the interface that carries control inputs and registered servo outputs.

package position_servo_pkg;
    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_CW    = 2'b01,
        DIR_CCW   = 2'b10,
        DIR_BRAKE = 2'b11
    } rotation_direction_t;
endpackage

interface position_servo_if #(
    parameter int unsigned W = 32,
    parameter int unsigned P = 16
) ();
    import position_servo_pkg::*;

    logic                enable;
    logic [W-1:0]        encoder_position;
    logic [W-1:0]        target_position;
    logic [P-1:0]        pwm_duty_in;
    rotation_direction_t dir_in;
    logic                fault_clear;

    logic [P-1:0]        pwm_duty_out;
    rotation_direction_t dir_out;
    logic                in_position;
    logic                fault;

    modport master (
        output enable, encoder_position, target_position, pwm_duty_in, dir_in, fault_clear,
        input  pwm_duty_out, dir_out, in_position, fault
    );

    modport slave (
        input  enable, encoder_position, target_position, pwm_duty_in, dir_in, fault_clear,
        output pwm_duty_out, dir_out, in_position, fault
    );
endinterface

// File: rtl/position_servo.sv
// Closed-loop position servo: proportional duty command with slew limiting,
// brake-on-reversal, settle/hold detection and a latched stall fault.
// Every output is registered and reflects the previous cycle's inputs.

module position_servo
    import position_servo_pkg::*;
#(
    parameter int unsigned clk_freq_hz       = 50_000_000,
    parameter int unsigned counter_width     = 32,
    parameter int unsigned pwm_counter_width = 16,
    parameter int unsigned deadband          = 2,
    parameter int unsigned kp_shift          = 0,
    parameter int unsigned slew_step         = 1000,
    parameter int unsigned settle_cycles     = 4,
    parameter int unsigned stall_cycles      = 100
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    position_servo_if.slave   bus
);

    localparam int unsigned W = counter_width;
    localparam int unsigned P = pwm_counter_width;

    localparam int unsigned SETTLE_CW = (settle_cycles < 1) ? 1 : $clog2(settle_cycles + 1);
    localparam int unsigned STALL_CW  = (stall_cycles < 1)  ? 1 : $clog2(stall_cycles + 1);

    localparam logic [SETTLE_CW-1:0] SETTLE_TARGET = SETTLE_CW'(settle_cycles);
    localparam logic [SETTLE_CW-1:0] SETTLE_MAX    = '1;
    localparam logic [STALL_CW-1:0]  STALL_TARGET  = STALL_CW'(stall_cycles);
    localparam logic [STALL_CW-1:0]  STALL_MAX     = '1;

    localparam logic [W-1:0] HALF_RANGE = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] DEADBAND_W = W'(deadband);

    // Slew step clipped to the duty range so the ramp adder stays P+1 bits wide.
    localparam longint unsigned SLEW_L     = longint'(slew_step);
    localparam longint unsigned DUTY_MAX_L = (64'd1 << P) - 64'd1;
    localparam logic [P-1:0]    SLEW_P     = P'((SLEW_L > DUTY_MAX_L) ? DUTY_MAX_L : SLEW_L);

    if (clk_freq_hz == 0) begin : gBadClock
        $error("position_servo: clk_freq_hz must be nonzero");
    end

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_TRACK,
        ST_SETTLE,
        ST_HOLD,
        ST_FAULT
    } state_t;

    state_t              state_q, state_d;
    rotation_direction_t dir_q, dir_d;
    logic [P-1:0]        duty_q, duty_d;
    logic                inPos_q, inPos_d;
    logic                fault_q, fault_d;
    logic [SETTLE_CW-1:0] settleCnt_q, settleCnt_d;
    logic [STALL_CW-1:0]  stallCnt_q, stallCnt_d;
    logic [W-1:0]        best_q, best_d;
    logic [W-1:0]        prevTarget_q;

    logic [W-1:0]        errorRaw;
    logic                isCcw;
    logic [W-1:0]        errorMag;
    rotation_direction_t errDir;
    logic                onTarget;
    logic [W-1:0]        magScaled;
    logic [P-1:0]        magSat;
    logic [P-1:0]        cmd;
    logic [P-1:0]        rampBase;
    logic [P:0]          rampSum;
    logic [P-1:0]        rampLimit;
    logic [P-1:0]        trackDuty;
    logic                reversal;
    logic                targetMoved;
    logic                improved;
    logic [STALL_CW-1:0] stallInc;
    logic [STALL_CW-1:0] stallNext;
    logic [SETTLE_CW-1:0] settleInc;

    assign errorRaw  = bus.target_position - bus.encoder_position;
    assign isCcw     = errorRaw > HALF_RANGE;
    assign errorMag  = isCcw ? (W'(0) - errorRaw) : errorRaw;
    assign errDir    = isCcw ? DIR_CCW : DIR_CW;
    assign onTarget  = errorMag <= DEADBAND_W;
    assign magScaled = errorMag >> kp_shift;

    if (W > P) begin : gSatWide
        assign magSat = (|magScaled[W-1:P]) ? '1 : magScaled[P-1:0];
    end else begin : gSatNarrow
        assign magSat = P'(magScaled);
    end

    assign cmd       = (magSat < bus.pwm_duty_in) ? magSat : bus.pwm_duty_in;
    assign rampBase  = (state_q == ST_TRACK) ? duty_q : '0;
    assign rampSum   = {1'b0, rampBase} + {1'b0, SLEW_P};
    assign rampLimit = rampSum[P] ? '1 : rampSum[P-1:0];
    assign trackDuty = (cmd < rampLimit) ? cmd : rampLimit;

    assign reversal  = (state_q == ST_TRACK) &&
                       (((dir_q == DIR_CW) && (errDir == DIR_CCW)) ||
                        ((dir_q == DIR_CCW) && (errDir == DIR_CW)));

    assign targetMoved = bus.target_position != prevTarget_q;
    assign improved    = errorMag < best_q;
    assign stallInc    = (stallCnt_q == STALL_MAX) ? stallCnt_q : stallCnt_q + STALL_CW'(1);
    assign stallNext   = (targetMoved || improved) ? '0 : stallInc;
    assign settleInc   = (settleCnt_q == SETTLE_MAX) ? settleCnt_q : settleCnt_q + SETTLE_CW'(1);

    // Next-state and counter logic; entering TRACK always re-arms the stall monitor.
    always_comb begin
        logic enterTrack;
        state_d     = state_q;
        settleCnt_d = settleCnt_q;
        stallCnt_d  = stallCnt_q;
        best_d      = best_q;
        enterTrack  = 1'b0;

        unique case (state_q)
            ST_DISABLED: begin
                settleCnt_d = '0;
                stallCnt_d  = '0;
                if (bus.enable) begin
                    if (onTarget) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d    = ST_TRACK;
                        enterTrack = 1'b1;
                    end
                end
            end
            ST_TRACK: begin
                if (!bus.enable) begin
                    state_d     = ST_DISABLED;
                    settleCnt_d = '0;
                    stallCnt_d  = '0;
                end else if (onTarget) begin
                    state_d     = ST_SETTLE;
                    settleCnt_d = '0;
                    stallCnt_d  = '0;
                end else begin
                    stallCnt_d = stallNext;
                    if (targetMoved || improved) begin
                        best_d = errorMag;
                    end
                    if (stallNext >= STALL_TARGET) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_SETTLE: begin
                if (!bus.enable) begin
                    state_d     = ST_DISABLED;
                    settleCnt_d = '0;
                end else if (!onTarget) begin
                    state_d     = ST_TRACK;
                    settleCnt_d = '0;
                    enterTrack  = 1'b1;
                end else begin
                    settleCnt_d = settleInc;
                    if (settleInc >= SETTLE_TARGET) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!bus.enable) begin
                    state_d     = ST_DISABLED;
                    settleCnt_d = '0;
                end else if (!onTarget) begin
                    state_d     = ST_TRACK;
                    settleCnt_d = '0;
                    enterTrack  = 1'b1;
                end
            end
            ST_FAULT: begin
                if (bus.fault_clear) begin
                    settleCnt_d = '0;
                    stallCnt_d  = '0;
                    if (!bus.enable) begin
                        state_d = ST_DISABLED;
                    end else if (onTarget) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d    = ST_TRACK;
                        enterTrack = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_DISABLED;
                settleCnt_d = '0;
                stallCnt_d  = '0;
            end
        endcase

        if (enterTrack) begin
            best_d     = errorMag;
            stallCnt_d = '0;
        end
    end

    // Output values for the state being entered, so they land with latency 1.
    always_comb begin
        dir_d   = DIR_BRAKE;
        duty_d  = '0;
        inPos_d = 1'b0;
        fault_d = 1'b0;

        unique case (state_d)
            ST_DISABLED: begin
                dir_d  = bus.dir_in;
                duty_d = bus.pwm_duty_in;
            end
            ST_TRACK: begin
                if (!reversal) begin
                    dir_d  = errDir;
                    duty_d = trackDuty;
                end
            end
            ST_SETTLE: begin
            end
            ST_HOLD: begin
                inPos_d = 1'b1;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, output and monitor registers; reset drops everything immediately.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_DISABLED;
            dir_q        <= DIR_NONE;
            duty_q       <= '0;
            inPos_q      <= 1'b0;
            fault_q      <= 1'b0;
            settleCnt_q  <= '0;
            stallCnt_q   <= '0;
            best_q       <= '0;
            prevTarget_q <= '0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            duty_q       <= duty_d;
            inPos_q      <= inPos_d;
            fault_q      <= fault_d;
            settleCnt_q  <= settleCnt_d;
            stallCnt_q   <= stallCnt_d;
            best_q       <= best_d;
            prevTarget_q <= bus.target_position;
        end
    end

    assign bus.dir_out      = dir_q;
    assign bus.pwm_duty_out = duty_q;
    assign bus.in_position  = inPos_q;
    assign bus.fault        = fault_q;

endmodule
